// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the I2S clock generator.
package i2s_pkg;

  localparam int MCLK_HALF_DFLT      = 2;
  localparam int BCLK_HALF_DFLT      = 16;
  localparam int SLOT_BITS_DFLT      = 16;
  localparam int STARTUP_CYCLES_DFLT = 512;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_RUN,
    ST_STOPPING
  } state_t;

endpackage

// File: rtl/clk_toggle_div.sv
// Half-period counter: strobes tgl on the last cycle of each half-period.
module clk_toggle_div
  import i2s_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] half,
  output logic         tgl
);

  logic [W-1:0] cnt;

  assign tgl = !clear && (cnt == half - W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tgl) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/i2s_clock_gen.sv
// MCLK/BCLK/LRCLK generator with startup hold, clean stop and
// frame-aligned runtime ratio changes.
//
// state       | meaning
// ST_STARTUP  | post-reset hold, every output low
// ST_IDLE     | mclk running, bclk/lrclk parked low
// ST_RUN      | bclk/lrclk generation active
// ST_STOPPING | enable dropped, finishing the current frame
module i2s_clock_gen
  import i2s_pkg::*;
#(
  parameter int MCLK_HALF      = MCLK_HALF_DFLT,
  parameter int BCLK_HALF_W    = 8,
  parameter int SLOT_W         = 6,
  parameter int DEF_BCLK_HALF  = BCLK_HALF_DFLT,
  parameter int DEF_SLOT_BITS  = SLOT_BITS_DFLT,
  parameter int STARTUP_CYCLES = STARTUP_CYCLES_DFLT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   cfg_valid,
  input  logic [BCLK_HALF_W-1:0] cfg_bclk_half,
  input  logic [SLOT_W-1:0]      cfg_slot_bits,
  output logic                   mclk,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   bclk_rise,
  output logic                   bclk_fall,
  output logic                   frame_start,
  output logic                   running,
  output logic                   cfg_pending
);

  localparam int MCLK_W  = $clog2(MCLK_HALF) + 1;
  localparam int START_W = $clog2(STARTUP_CYCLES + 1);

  state_t state, state_nxt;

  logic [START_W-1:0]     start_cnt;
  logic [SLOT_W-1:0]      bitcnt;
  logic [BCLK_HALF_W-1:0] bclk_half_act, bclk_half_pend;
  logic [SLOT_W-1:0]      slot_bits_act, slot_bits_pend;

  logic gen_active, mclk_tgl, bclk_tgl;
  logic rise_c, fall_c, slot_end, boundary, stop_now, enter_run;

  clk_toggle_div #(.W(MCLK_W)) u_mclk_div (
    .clk   (clk),
    .reset (reset),
    .clear (state == ST_STARTUP),
    .half  (MCLK_W'(MCLK_HALF)),
    .tgl   (mclk_tgl)
  );

  clk_toggle_div #(.W(BCLK_HALF_W)) u_bclk_div (
    .clk   (clk),
    .reset (reset),
    .clear (!gen_active),
    .half  (bclk_half_act),
    .tgl   (bclk_tgl)
  );

  assign gen_active = (state == ST_RUN) || (state == ST_STOPPING);
  assign rise_c     = bclk_tgl && !bclk;
  assign fall_c     = bclk_tgl && bclk;
  assign slot_end   = fall_c && (bitcnt == slot_bits_act - SLOT_W'(1));
  assign boundary   = slot_end && lrclk;
  assign stop_now   = (state == ST_STOPPING) && !enable && boundary;
  assign enter_run  = (state_nxt == ST_RUN) && !gen_active;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STARTUP:
        if (start_cnt == START_W'(STARTUP_CYCLES - 1))
          state_nxt = enable ? ST_RUN : ST_IDLE;
      ST_IDLE:     if (enable)  state_nxt = ST_RUN;
      ST_RUN:      if (!enable) state_nxt = ST_STOPPING;
      ST_STOPPING:
        if (enable)        state_nxt = ST_RUN;
        else if (boundary) state_nxt = ST_IDLE;
      default:     state_nxt = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_STARTUP;
      start_cnt      <= '0;
      mclk           <= 1'b0;
      bclk           <= 1'b0;
      lrclk          <= 1'b0;
      bitcnt         <= '0;
      bclk_rise      <= 1'b0;
      bclk_fall      <= 1'b0;
      frame_start    <= 1'b0;
      running        <= 1'b0;
      bclk_half_act  <= BCLK_HALF_W'(DEF_BCLK_HALF);
      slot_bits_act  <= SLOT_W'(DEF_SLOT_BITS);
      bclk_half_pend <= '0;
      slot_bits_pend <= '0;
      cfg_pending    <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN) || (state_nxt == ST_STOPPING);

      if (state == ST_STARTUP) begin
        start_cnt <= start_cnt + START_W'(1);
        mclk      <= 1'b0;
      end else if (mclk_tgl) begin
        mclk <= ~mclk;
      end

      if (!gen_active) begin
        bclk   <= 1'b0;
        lrclk  <= 1'b0;
        bitcnt <= '0;
      end else begin
        if (bclk_tgl) bclk <= ~bclk;
        if (slot_end) begin
          bitcnt <= '0;
          lrclk  <= ~lrclk;
        end else if (fall_c) begin
          bitcnt <= bitcnt + SLOT_W'(1);
        end
      end

      // The final fall of a stopping frame parks the clocks without strobes.
      bclk_rise   <= rise_c && !stop_now;
      bclk_fall   <= fall_c && !stop_now;
      frame_start <= enter_run || (boundary && !stop_now);

      if (boundary && cfg_pending) begin
        bclk_half_act <= bclk_half_pend;
        slot_bits_act <= slot_bits_pend;
        cfg_pending   <= 1'b0;
      end
      // A load coincident with a boundary stays pending for the next one.
      if (cfg_valid) begin
        bclk_half_pend <= (cfg_bclk_half == '0) ? BCLK_HALF_W'(1) : cfg_bclk_half;
        slot_bits_pend <= (cfg_slot_bits == '0) ? SLOT_W'(1) : cfg_slot_bits;
        cfg_pending    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_clock_gen.sv
// Self-checking bench: frame-position model checked every cycle, plus
// directed period/latency measurements with hand-computed expectations.
module tb_i2s_clock_gen;

  localparam int MCLK_HALF = 2;
  localparam int STARTUP   = 512;
  localparam int M_START = 0, M_IDLE = 1, M_RUN = 2, M_STOP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_bclk_half = '0;
  logic [5:0] cfg_slot_bits = '0;
  logic mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, running, cfg_pending;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  i2s_clock_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_bclk_half(cfg_bclk_half), .cfg_slot_bits(cfg_slot_bits),
    .mclk(mclk), .bclk(bclk), .lrclk(lrclk), .bclk_rise(bclk_rise),
    .bclk_fall(bclk_fall), .frame_start(frame_start), .running(running),
    .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  // Model: position p within the current frame (frame = 4*slot*half clk).
  int m_mode, m_scnt, m_mt, m_p, m_half, m_slot, m_phalf, m_pslot, h2;
  bit m_pend, entered, bnd;
  logic [7:0] exp_vec;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_START; m_scnt = 0; m_mt = 0; m_p = 0;
      m_half = 16; m_slot = 16; m_phalf = 0; m_pslot = 0; m_pend = 1'b0;
      exp_vec = '0;
    end else begin
      entered = 1'b0; bnd = 1'b0;
      if (m_mode == M_START) begin
        m_scnt++;
        if (m_scnt == STARTUP) begin
          m_mt = 0;
          if (enable) begin m_mode = M_RUN; entered = 1'b1; m_p = 0; end
          else m_mode = M_IDLE;
        end
      end else begin
        m_mt++;
        if (m_mode == M_IDLE) begin
          if (enable) begin m_mode = M_RUN; entered = 1'b1; m_p = 0; end
        end else begin
          m_p++;
          if (m_p == 4 * m_slot * m_half) begin bnd = 1'b1; m_p = 0; end
          if (m_mode == M_RUN) begin
            if (!enable) m_mode = M_STOP;
          end else if (enable) m_mode = M_RUN;
          else if (bnd) m_mode = M_IDLE;
        end
      end
      if (bnd && m_pend) begin m_half = m_phalf; m_slot = m_pslot; m_pend = 1'b0; end
      if (cfg_valid) begin
        m_phalf = (cfg_bclk_half == 0) ? 1 : int'(cfg_bclk_half);
        m_pslot = (cfg_slot_bits == 0) ? 1 : int'(cfg_slot_bits);
        m_pend  = 1'b1;
      end
      exp_vec = '0;
      exp_vec[7] = (m_mode != M_START) && (((m_mt / MCLK_HALF) % 2) == 1);
      exp_vec[0] = m_pend;
      if (m_mode == M_RUN || m_mode == M_STOP) begin
        h2 = 2 * m_half;
        exp_vec[6] = ((m_p / m_half) % 2) == 1;
        exp_vec[5] = m_p >= m_slot * h2;
        exp_vec[4] = (m_p % h2) == m_half;
        exp_vec[3] = ((m_p % h2) == 0) && !entered;
        exp_vec[2] = m_p == 0;
        exp_vec[1] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if ({mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, running, cfg_pending} !== exp_vec) begin
        errors++;
        if (errors < 30)
          $display("FAIL model_compare t=%0t got mclk,bclk,lr,rise,fall,fs,run,pend=%b expected %b",
                   $time, {mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, running, cfg_pending}, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns number of negedges until the selected event; -1 on timeout.
  task automatic wait_sig(input int sel, output int n);
    logic prev, cur;
    bit hit;
    prev = mclk; n = 0; hit = 1'b0;
    while (!hit && n < 3000) begin
      @(negedge clk);
      n++;
      case (sel)
        0: begin cur = mclk; hit = !prev && cur; prev = cur; end
        1: hit = bclk_rise;
        2: hit = frame_start;
        3: hit = running;
        default: hit = !running;
      endcase
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL wait_timeout sel=%0d got no event expected one within 3000 cycles", sel);
      n = -1;
    end
  endtask

  task automatic load_cfg(input int h, input int s);
    cfg_bclk_half = 8'(h);
    cfg_slot_bits = 6'(s);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  int n;

  initial begin
    #1 reset = 1'b1;
    #1 chk("reset_outputs", int'({mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, running, cfg_pending}), 0);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Defaults with enable held high.
    wait_sig(3, n); chk("startup_len", n, 512);
    chk("entry_frame_start", int'(frame_start), 1);
    wait_sig(1, n); chk("first_bclk_rise", n, 16);
    wait_sig(0, n); wait_sig(0, n); chk("mclk_period", n, 4);
    wait_sig(1, n); wait_sig(1, n); chk("bclk_period", n, 32);
    wait_sig(2, n);
    chk("boundary_fall_lr", int'({bclk_fall, lrclk}), 2);
    wait_sig(2, n); chk("frame_period", n, 1024);

    // Mid-frame config: current frame keeps its length.
    repeat (200) @(negedge clk);
    load_cfg(8, 32);
    chk("cfg_pending_set", int'(cfg_pending), 1);
    wait_sig(2, n); chk("old_frame_kept", n, 823);
    chk("cfg_pending_clr", int'(cfg_pending), 0);
    wait_sig(1, n); chk("new_first_rise", n, 8);
    wait_sig(1, n); chk("new_bclk_period", n, 16);
    wait_sig(2, n); chk("new_frame_len", n, 1000);

    // Two loads in one frame: last wins.
    load_cfg(4, 8);
    repeat (50) @(negedge clk);
    load_cfg(2, 4);
    wait_sig(2, n); chk("frame_before_apply", n, 972);
    wait_sig(2, n); chk("second_cfg_frame", n, 32);

    // Load coincident with a boundary, zero values clamp to 1.
    repeat (31) @(negedge clk);
    load_cfg(0, 0);
    chk("sim_boundary_fs", int'(frame_start), 1);
    chk("sim_pending_kept", int'(cfg_pending), 1);
    wait_sig(2, n); chk("old_frame_after_sim", n, 32);
    wait_sig(2, n); chk("clamped_frame", n, 4);
    wait_sig(1, n); wait_sig(1, n); chk("clamped_bclk", n, 2);

    // Back to defaults, then stop in the right slot and restart.
    load_cfg(16, 16);
    wait_sig(2, n);
    chk("restore_applied", int'(cfg_pending), 0);
    repeat (600) @(negedge clk);
    chk("right_slot", int'(lrclk), 1);
    enable = 1'b0;
    wait_sig(4, n); chk("stop_at_boundary", n, 424);
    chk("stopped_quiet", int'({bclk, lrclk, frame_start, bclk_fall}), 0);
    wait_sig(0, n); wait_sig(0, n); chk("mclk_free_run", n, 4);
    enable = 1'b1;
    wait_sig(2, n); chk("restart_frame_start", n, 1);
    chk("restart_running", int'(running), 1);
    wait_sig(1, n); chk("restart_first_rise", n, 16);

    // Reset mid-frame with non-default active and pending config.
    load_cfg(4, 8);
    wait_sig(2, n);
    load_cfg(2, 2);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("reset_async_clear", int'({mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, running, cfg_pending}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_sig(3, n); chk("restart_startup", n, 512);
    wait_sig(1, n); chk("defaults_restored", n, 16);
    wait_sig(2, n); chk("default_frame", n, 1008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_clock_gen.md
Name: i2s_clock_gen

Overview:
Parametrised audio clock generator that replaces the fixed-tap divider derivation of MCLK/BCLK/LRCLK in the top level. It produces MCLK, BCLK and LRCLK from the system clock, with BCLK and frame ratios programmable at run time. New ratios take effect only on a frame boundary. It also supplies a startup hold, an enable with clean stop, and single-cycle edge strobes for the i2s_rx/i2s_tx blocks and sample-rate logic (e.g. a phase-accumulator NCO).

Parameters:
MCLK_HALF, 2, clk cycles per MCLK half-period (>=1); 49.152 MHz -> 12.288 MHz
BCLK_HALF_W, 8, width of bclk_half config field
SLOT_W, 6, width of slot_bits config field
DEF_BCLK_HALF, 16, bclk_half loaded at reset (BCLK = clk/32)
DEF_SLOT_BITS, 16, slot_bits loaded at reset (LRCLK = clk/1024 = 48 kHz)
STARTUP_CYCLES, 512, clk cycles after reset release before clocks start

Ports:
clk  in  1  system clock (OSC domain)
reset  in  1  asynchronous, active-high
enable  in  1  run request; sampled every clk
cfg_valid  in  1  one-cycle load strobe for cfg_* fields
cfg_bclk_half  in  BCLK_HALF_W  clk cycles per BCLK half-period
cfg_slot_bits  in  SLOT_W  BCLK cycles per LRCLK half-period (per channel)
mclk  out  1  master clock
bclk  out  1  bit clock
lrclk  out  1  word select; 0 = left, 1 = right
bclk_rise  out  1  high in the clk cycle bclk first reads 1
bclk_fall  out  1  high in the clk cycle bclk first reads 0
frame_start  out  1  high in the clk cycle lrclk first reads 0 (left slot begins)
running  out  1  BCLK/LRCLK generation active
cfg_pending  out  1  a loaded config awaits the next frame boundary

Behaviour:
- Outputs are registered. Reset value of every output is 0. Active config resets to DEF_*. Pending register is cleared. Startup counter is cleared.
- Startup: after reset deasserts, count STARTUP_CYCLES clk cycles with all outputs 0. Then the state moves from STARTUP to IDLE (or RUN if enable=1). mclk starts toggling on leaving STARTUP and free-runs from then on, independent of enable.
- mclk: toggles when its counter reaches MCLK_HALF-1; the counter then wraps to 0.
- States: STARTUP -> IDLE/RUN; IDLE -> RUN when enable=1; RUN -> STOPPING when enable=0; STOPPING -> IDLE at the next frame boundary, or back to RUN if enable returns first.
- running=1 in RUN and STOPPING.
- On entering RUN from IDLE: bclk=0, lrclk=0, all counters 0, and frame_start pulses in that first cycle.
- bclk: the half-period counter hc increments each clk. At hc==bclk_half_act-1, bclk toggles and hc wraps. Period = 2*bclk_half_act clk cycles. The first bclk rise comes bclk_half_act cycles after RUN entry.
- Bit counter: increments on every bclk fall. On the fall where bitcnt==slot_bits_act-1, lrclk toggles and bitcnt wraps. Result: lrclk changes only coincident with bclk falling, as I2S requires.
- Frame boundary: a bclk fall that drives lrclk 1->0. frame_start pulses in that same cycle.
- Config load: cfg_valid copies the cfg_* fields into the pending register and sets cfg_pending. A later cfg_valid overwrites the pending values (last wins).
- Config apply: at a frame boundary with cfg_pending=1 (registered before that cycle), pending becomes active, cfg_pending clears, and hc restarts from 0 under the new value.
- Simultaneous cfg_valid and frame boundary: the new values go to pending only; they apply at the following boundary.
- Clamping: a bclk_half or slot_bits value of 0 is stored as 1. No other range check.
- STOPPING -> IDLE: at the frame boundary, bclk and lrclk are forced to 0, no frame_start is issued, and strobes go quiet. A pending config applies on that boundary.
- Reset mid-operation: immediate return to reset values; startup count restarts.

Decomposition:
- Package i2s_pkg: DEF_* ratio constants, MCLK_HALF default, STARTUP_CYCLES, and the state enum (STARTUP, IDLE, RUN, STOPPING).
- Sub-module clk_toggle_div: programmable half-period toggler with clear input and toggle strobe output. Instantiated twice, for mclk (constant half) and bclk (runtime half).

Test Plan:
- Defaults, enable=1: running rises at cycle 512. mclk period 4 clk. bclk period 32 clk. lrclk period 1024 clk. frame_start every 1024 clk. Each lrclk edge coincides with a bclk_fall.
- Mid-frame cfg_valid with bclk_half=8, slot_bits=32: cfg_pending=1 until the next frame_start. After it, bclk period 16 and lrclk period 1024. The current frame is unchanged.
- cfg_valid on the same cycle as frame_start, then a second cfg_valid before the next boundary: only the second value applies, one frame later.
- cfg_bclk_half=0, cfg_slot_bits=0: bclk period 2 clk, lrclk period 4 clk after the boundary.
- enable=0 mid-right-slot: the frame completes, then bclk=lrclk=0 and running=0 while mclk keeps toggling. enable=1: frame_start in the first cycle and the first bclk rise 16 cycles later.
- reset pulse mid-frame: all outputs 0 within the reset cycle. Defaults restored. Clocks resume 512 cycles after release.
